// File: rtl/alu_sr_seq.sv
// Multi-cycle right shifter (SRL/SRA): one log2 stage (1,2,4,8,16) per clock, valid/ready handshake.
// Optional rotate-right mode enabled by defining ALU_SR_ROTATE_EN (adds ctrl_rotate).
module alu_sr_seq #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  data_operandA,
  input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
  input  logic                   ctrl_arith,
`ifdef ALU_SR_ROTATE_EN
  input  logic                   ctrl_rotate,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  result_sr,
  output logic                   busy
);

  localparam int unsigned CW = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
  localparam int unsigned SW = SHAMT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [DATA_WIDTH-1:0]  res_q, res_d;
  logic [SHAMT_WIDTH-1:0] amt_q, amt_d;
  logic                   fill_q, fill_d;
  logic                   rot_q, rot_d;

  logic [SW-1:0]          sh;
  logic [DATA_WIDTH-1:0]  ones;
  logic [DATA_WIDTH-1:0]  stage_v;
  logic [DATA_WIDTH-1:0]  next_work;

  // Current stage: shift by 2**cnt_q with fill (sign/zero) or wrap-around (rotate).
  always_comb begin
    ones    = '1;
    sh      = SW'(1) << cnt_q;
    stage_v = work_q >> sh;
    if (rot_q) begin
      stage_v = stage_v | (work_q << (SW'(DATA_WIDTH) - sh));
    end else if (fill_q) begin
      stage_v = stage_v | ~(ones >> sh);
    end
    next_work = amt_q[cnt_q] ? stage_v : work_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    res_d   = res_q;
    amt_d   = amt_q;
    fill_d  = fill_q;
    rot_d   = rot_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data_operandA;
          amt_d   = ctrl_shiftamt;
          fill_d  = ctrl_arith & data_operandA[DATA_WIDTH-1];
`ifdef ALU_SR_ROTATE_EN
          rot_d   = ctrl_rotate;
`else
          rot_d   = 1'b0;
`endif
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = next_work;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(SHAMT_WIDTH - 1)) begin
          // Result register is loaded alongside the last stage so it holds after DONE.
          res_d   = next_work;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
      amt_q   <= '0;
      fill_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      res_q   <= res_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      rot_q   <= rot_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result_sr = res_q;

endmodule

// File: tb/tb_alu_sr_seq.sv
// Directed bench for alu_sr_seq: latency, shift results, backpressure and reset abort.
// Rotate vectors are included when ALU_SR_ROTATE_EN is defined.
module tb_alu_sr_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic        ctrl_arith;
`ifdef ALU_SR_ROTATE_EN
  logic        ctrl_rotate;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_sr;
  logic        busy;

  int unsigned vec_cnt  = 0;
  int unsigned miss_cnt = 0;

  alu_sr_seq #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_operandA(data_operandA),
    .ctrl_shiftamt(ctrl_shiftamt),
    .ctrl_arith   (ctrl_arith),
`ifdef ALU_SR_ROTATE_EN
    .ctrl_rotate  (ctrl_rotate),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_sr    (result_sr),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one request for the accept edge; leaves the bench 1 time unit after it.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                          input logic ar, input logic rot);
    check_eq({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
    data_operandA = a;
    ctrl_shiftamt = sh;
    ctrl_arith    = ar;
`ifdef ALU_SR_ROTATE_EN
    ctrl_rotate   = rot;
`else
    if (rot) $display("note: rotate request ignored in this build");
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp);
    int unsigned cyc = 0;
    logic        rdy_seen = 1'b0;
    while (!out_valid && cyc < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      cyc++;
    end
    check_eq({tag, ":latency"}, cyc, 32'd5);
    check_eq({tag, ":rdy_low"}, {31'd0, rdy_seen}, 32'd0);
    check_eq({tag, ":result"}, result_sr, exp);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, ":ov_drop"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, ":rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                        input logic ar, input logic rot, input logic [31:0] exp);
    start_op(tag, a, sh, ar, rot);
    wait_done(tag, exp);
    drain(tag);
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    ctrl_arith    = 1'b0;
`ifdef ALU_SR_ROTATE_EN
    ctrl_rotate   = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst:in_ready",  {31'd0, in_ready},  32'd1);
    check_eq("rst:out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst:busy",      {31'd0, busy},      32'd0);
    check_eq("rst:result",    result_sr,          32'h0);

    run_op("sra_80_4",   32'h8000_0000, 5'd4,  1'b1, 1'b0, 32'hF800_0000);
    run_op("srl_80_4",   32'h8000_0000, 5'd4,  1'b0, 1'b0, 32'h0800_0000);
    run_op("sra_80_31",  32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_op("srl_ff_31",  32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h0000_0001);
    run_op("srl_7f_31",  32'h7FFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h0000_0000);
    run_op("sra_7f_31",  32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, 32'h0000_0000);
    run_op("sra_sh0",    32'h1234_5678, 5'd0,  1'b1, 1'b0, 32'h1234_5678);
    run_op("sra_pos_5",  32'h1234_5678, 5'd5,  1'b1, 1'b0, 32'h0091_A2B3);
    run_op("sra_neg_12", 32'h8765_4321, 5'd12, 1'b1, 1'b0, 32'hFFF8_7654);
    run_op("srl_neg_12", 32'h8765_4321, 5'd12, 1'b0, 1'b0, 32'h0008_7654);

    // Backpressure: hold DONE for 3 cycles while a new request is offered.
    start_op("bp", 32'h8000_0000, 5'd4, 1'b1, 1'b0);
    wait_done("bp", 32'hF800_0000);
    data_operandA = 32'h1111_1111;
    ctrl_shiftamt = 5'd1;
    ctrl_arith    = 1'b0;
    in_valid      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp:ov_hold",  {31'd0, out_valid}, 32'd1);
      check_eq("bp:res_hold", result_sr,          32'hF800_0000);
      check_eq("bp:rdy_low",  {31'd0, in_ready},  32'd0);
      tick();
    end
    in_valid = 1'b0;
    drain("bp");
    check_eq("bp:busy",      {31'd0, busy}, 32'd0);
    check_eq("bp:res_after", result_sr,     32'hF800_0000);
    tick();
    check_eq("bp:not_taken", {31'd0, busy}, 32'd0);

    // Reset during the third SHIFT cycle aborts the operation.
    start_op("rst_mid", 32'hF000_0000, 5'd8, 1'b1, 1'b0);
    tick();
    tick();
    check_eq("rst_mid:busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_mid:in_ready", {31'd0, in_ready},  32'd1);
    check_eq("rst_mid:ov",       {31'd0, out_valid}, 32'd0);
    check_eq("rst_mid:result",   result_sr,          32'h0);
    begin
      logic ov_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (out_valid) ov_seen = 1'b1;
        tick();
      end
      check_eq("rst_mid:no_ov", {31'd0, ov_seen}, 32'd0);
    end
    run_op("rst_mid:redo", 32'hF000_0000, 5'd8, 1'b1, 1'b0, 32'hFFF0_0000);

    // Reset and in_valid together: nothing accepted.
    data_operandA = 32'hDEAD_BEEF;
    ctrl_shiftamt = 5'd3;
    in_valid      = 1'b1;
    reset         = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check_eq("rst_vld:busy",   {31'd0, busy}, 32'd0);
    check_eq("rst_vld:result", result_sr,     32'h0);

`ifdef ALU_SR_ROTATE_EN
    run_op("rot_1_1",   32'h0000_0001, 5'd1,  1'b1, 1'b1, 32'h8000_0000);
    run_op("rot_16",    32'h1234_5678, 5'd16, 1'b0, 1'b1, 32'h5678_1234);
    run_op("rot_4",     32'h8765_4321, 5'd4,  1'b1, 1'b1, 32'h1876_5432);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
